// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: mode records for the supported rasters and
// helpers that turn porch/sync/active widths into line and frame totals.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
    logic [15:0] acc_inc;
  } vga_mode_t;

  // 640x480@60: 25 MHz pixel rate from 100 MHz (ACC_INC / 2^16 = 1/4).
  localparam vga_mode_t MODE_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0, acc_inc: 16'h4000
  };

  // 800x600@60: 40 MHz pixel rate from 100 MHz (ACC_INC / 2^16 = 0.4).
  localparam vga_mode_t MODE_800X600 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol: 1'b1, v_pol: 1'b1, acc_inc: 16'h6666
  };

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the timing generator to the downstream renderer.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 11
);
  logic          o_pix_stb;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_active;
  logic          o_h_blank;
  logic          o_v_blank;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_line_start;
  logic          o_frame_start;

  modport master (
    output o_pix_stb, o_hsync, o_vsync, o_active, o_h_blank, o_v_blank,
           o_x, o_y, o_line_start, o_frame_start
  );

  modport slave (
    input  o_pix_stb, o_hsync, o_vsync, o_active, o_h_blank, o_v_blank,
           o_x, o_y, o_line_start, o_frame_start
  );
endinterface

// File: rtl/frac_clk_en.sv
// Fractional clock enable: phase accumulator whose carry, registered, gives a
// one-clock strobe at an average rate of ACC_INC / 2^ACC_W of the input clock.
module frac_clk_en #(
  parameter int unsigned       ACC_W   = 16,
  parameter logic [ACC_W-1:0]  ACC_INC = 16'h4000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_stb
);

  logic [ACC_W-1:0] acc;

  // Accumulate every clock; the carry out of the add is the strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {o_stb, acc} <= '0;
    end else begin
      {o_stb, acc} <= {1'b0, acc} + {1'b0, ACC_INC};
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, h/v counters in active-first
// order (active, front porch, sync, back porch) and registered raster outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned      H_ACTIVE = MODE_640X480.h_active,
  parameter int unsigned      H_FP     = MODE_640X480.h_fp,
  parameter int unsigned      H_SYNC   = MODE_640X480.h_sync,
  parameter int unsigned      H_BP     = MODE_640X480.h_bp,
  parameter int unsigned      V_ACTIVE = MODE_640X480.v_active,
  parameter int unsigned      V_FP     = MODE_640X480.v_fp,
  parameter int unsigned      V_SYNC   = MODE_640X480.v_sync,
  parameter int unsigned      V_BP     = MODE_640X480.v_bp,
  parameter logic             H_POL    = MODE_640X480.h_pol,
  parameter logic             V_POL    = MODE_640X480.v_pol,
  parameter int unsigned      ACC_W    = 16,
  parameter logic [ACC_W-1:0] ACC_INC  = MODE_640X480.acc_inc,
  parameter int unsigned      CW       = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned CNT_RANGE = 32'd1 << CW;

  if (H_TOTAL >= CNT_RANGE || V_TOTAL >= CNT_RANGE ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      ACC_INC == '0) begin : g_bad_cfg
    $fatal(1, "vga_timing_gen: invalid timing parameters");
  end

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          stb_int;
  logic          adv;
  logic [CW-1:0] h, v, h_nxt, v_nxt;
  logic          h_blank_nxt, v_blank_nxt, active_nxt, hsync_nxt, vsync_nxt;

  frac_clk_en #(
    .ACC_W   (ACC_W),
    .ACC_INC (ACC_INC)
  ) u_pix_en (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_stb (stb_int)
  );

  // Next raster position: step h on each enabled strobe, carry into v at line end.
  always_comb begin
    adv   = stb_int && i_en;
    h_nxt = h;
    v_nxt = v;
    if (adv) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_nxt = h + 1'b1;
      end
    end
  end

  // Decode the upcoming position so registered outputs line up with the counters.
  always_comb begin
    h_blank_nxt = (h_nxt >= H_ACT_END);
    v_blank_nxt = (v_nxt >= V_ACT_END);
    active_nxt  = !h_blank_nxt && !v_blank_nxt;
    hsync_nxt   = (h_nxt >= HS_BEGIN && h_nxt < HS_END) ? H_POL : !H_POL;
    vsync_nxt   = (v_nxt >= VS_BEGIN && v_nxt < VS_END) ? V_POL : !V_POL;
  end

  // Counter and output registers; without an advance the decode reproduces the
  // held position, so level outputs hold and pulses drop without extra muxing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h                 <= '0;
      v                 <= '0;
      vga.o_pix_stb     <= 1'b0;
      vga.o_line_start  <= 1'b0;
      vga.o_frame_start <= 1'b0;
      vga.o_hsync       <= !H_POL;
      vga.o_vsync       <= !V_POL;
      vga.o_active      <= 1'b1;
      vga.o_h_blank     <= 1'b0;
      vga.o_v_blank     <= 1'b0;
      vga.o_x           <= '0;
      vga.o_y           <= '0;
    end else begin
      h                 <= h_nxt;
      v                 <= v_nxt;
      vga.o_pix_stb     <= adv;
      vga.o_line_start  <= adv && (h_nxt == '0);
      vga.o_frame_start <= adv && (h_nxt == '0) && (v_nxt == '0);
      vga.o_hsync       <= hsync_nxt;
      vga.o_vsync       <= vsync_nxt;
      vga.o_active      <= active_nxt;
      vga.o_h_blank     <= h_blank_nxt;
      vga.o_v_blank     <= v_blank_nxt;
      vga.o_x           <= active_nxt ? h_nxt : '0;
      vga.o_y           <= v_blank_nxt ? '0 : v_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (640x480 default, 800x600
// positive polarity, and a tiny raster with a near-every-clock strobe), each
// compared every cycle against a strobe-count reference model, plus directed
// vectors and sequences for reset, line/frame timing, gating and mid-frame reset.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam vga_mode_t MODE_SMALL = '{
    h_active: 8, h_fp: 2, h_sync: 3, h_bp: 2,
    v_active: 4, v_fp: 1, v_sync: 2, v_bp: 1,
    h_pol: 1'b0, v_pol: 1'b0, acc_inc: 16'hFFFF
  };

  typedef struct packed {
    logic        stb, hs, vs, act, hb, vb, ls, fs;
    logic [10:0] x, y;
  } obs_t;

  typedef struct {
    longint n;
    logic   hs, act, hb, ls;
    int     x, y;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_bc = 1'b1;
  logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;
  logic done_b = 1'b0, done_c = 1'b0;

  int checks = 0;
  int errors = 0;

  vga_timing_gen_if #(.CW(11)) vif_a ();
  vga_timing_gen_if #(.CW(11)) vif_b ();
  vga_timing_gen_if #(.CW(11)) vif_c ();

  vga_timing_gen dut_a (.i_clk(clk), .i_rst(rst_a), .i_en(en_a), .vga(vif_a));

  vga_timing_gen #(
    .H_ACTIVE (MODE_800X600.h_active), .H_FP (MODE_800X600.h_fp),
    .H_SYNC   (MODE_800X600.h_sync),   .H_BP (MODE_800X600.h_bp),
    .V_ACTIVE (MODE_800X600.v_active), .V_FP (MODE_800X600.v_fp),
    .V_SYNC   (MODE_800X600.v_sync),   .V_BP (MODE_800X600.v_bp),
    .H_POL    (MODE_800X600.h_pol),    .V_POL (MODE_800X600.v_pol),
    .ACC_W    (16),                    .ACC_INC (MODE_800X600.acc_inc),
    .CW       (11)
  ) dut_b (.i_clk(clk), .i_rst(rst_bc), .i_en(en_b), .vga(vif_b));

  vga_timing_gen #(
    .H_ACTIVE (MODE_SMALL.h_active), .H_FP (MODE_SMALL.h_fp),
    .H_SYNC   (MODE_SMALL.h_sync),   .H_BP (MODE_SMALL.h_bp),
    .V_ACTIVE (MODE_SMALL.v_active), .V_FP (MODE_SMALL.v_fp),
    .V_SYNC   (MODE_SMALL.v_sync),   .V_BP (MODE_SMALL.v_bp),
    .H_POL    (MODE_SMALL.h_pol),    .V_POL (MODE_SMALL.v_pol),
    .ACC_W    (16),                  .ACC_INC (MODE_SMALL.acc_inc),
    .CW       (11)
  ) dut_c (.i_clk(clk), .i_rst(rst_bc), .i_en(en_c), .vga(vif_c));

  function automatic void chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  function automatic vga_mode_t mode_of(input int d);
    case (d)
      0:       return MODE_640X480;
      1:       return MODE_800X600;
      default: return MODE_SMALL;
    endcase
  endfunction

  // Number of accumulator wraps after t clocks of a 16-bit phase accumulator.
  function automatic longint wraps(input longint t, input logic [15:0] inc);
    return (t * longint'(inc)) >> 16;
  endfunction

  // Expected outputs after n pixel advances since reset, from raster arithmetic.
  function automatic obs_t model_out(input vga_mode_t m, input longint n, input logic adv);
    obs_t   o;
    longint ht, vt, h, v, hs0, vs0;
    ht   = longint'(m.h_active) + m.h_fp + m.h_sync + m.h_bp;
    vt   = longint'(m.v_active) + m.v_fp + m.v_sync + m.v_bp;
    h    = n % ht;
    v    = (n / ht) % vt;
    hs0  = longint'(m.h_active) + m.h_fp;
    vs0  = longint'(m.v_active) + m.v_fp;
    o.hb  = (h >= longint'(m.h_active));
    o.vb  = (v >= longint'(m.v_active));
    o.act = !o.hb && !o.vb;
    o.x   = o.act ? 11'(h) : 11'd0;
    o.y   = o.vb ? 11'd0 : 11'(v);
    o.hs  = (h >= hs0 && h < hs0 + m.h_sync) ? m.h_pol : !m.h_pol;
    o.vs  = (v >= vs0 && v < vs0 + m.v_sync) ? m.v_pol : !m.v_pol;
    o.stb = adv;
    o.ls  = adv && (h == 0);
    o.fs  = adv && (h == 0) && (v == 0);
    return o;
  endfunction

  longint t_m [3];
  longint n_m [3];
  logic   sint_m [3];
  logic   adv_m [3];

  // Reference model: clocks since reset drive the wrap count; enabled wraps advance n.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic r, e;
      r = (d == 0) ? rst_a : rst_bc;
      e = (d == 0) ? en_a : ((d == 1) ? en_b : en_c);
      if (r) begin
        t_m[d] = 0; n_m[d] = 0; sint_m[d] = 1'b0; adv_m[d] = 1'b0;
      end else begin
        adv_m[d] = sint_m[d] && e;
        if (adv_m[d]) n_m[d] = n_m[d] + 1;
        t_m[d] = t_m[d] + 1;
        sint_m[d] = wraps(t_m[d], mode_of(d).acc_inc) != wraps(t_m[d] - 1, mode_of(d).acc_inc);
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    obs_t got, want;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: got = {vif_a.o_pix_stb, vif_a.o_hsync, vif_a.o_vsync, vif_a.o_active, vif_a.o_h_blank,
                  vif_a.o_v_blank, vif_a.o_line_start, vif_a.o_frame_start, vif_a.o_x, vif_a.o_y};
        1: got = {vif_b.o_pix_stb, vif_b.o_hsync, vif_b.o_vsync, vif_b.o_active, vif_b.o_h_blank,
                  vif_b.o_v_blank, vif_b.o_line_start, vif_b.o_frame_start, vif_b.o_x, vif_b.o_y};
        default: got = {vif_c.o_pix_stb, vif_c.o_hsync, vif_c.o_vsync, vif_c.o_active, vif_c.o_h_blank,
                  vif_c.o_v_blank, vif_c.o_line_start, vif_c.o_frame_start, vif_c.o_x, vif_c.o_y};
      endcase
      want = model_out(mode_of(d), n_m[d], adv_m[d]);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL model_dut%0d n=%0d: got %h expected %h", d, n_m[d], got, want);
      end
    end
  end

  // Line-start pulses on the fast-strobe instance must never span two clocks.
  logic prev_ls_c = 1'b0;
  always @(negedge clk) begin
    if (vif_c.o_line_start) begin
      checks++;
      if (prev_ls_c) begin
        errors++;
        $display("FAIL c_line_start_width: got 2 clocks expected 1");
      end
    end
    prev_ls_c = vif_c.o_line_start;
  end

  task automatic run_a_to(input longint target);
    for (int g = 0; g < 20000 && n_m[0] < target; g++) @(negedge clk);
    if (n_m[0] != target) begin
      checks++; errors++;
      $display("FAIL nav_a: got %0d expected %0d", n_m[0], target);
    end
  endtask

  // Main sequence on the default-mode instance.
  initial begin
    vec_t vecs [9];
    int   k;
    logic seen;
    vecs[0] = '{n: 639, hs: 1, act: 1, hb: 0, ls: 0, x: 639, y: 0};
    vecs[1] = '{n: 640, hs: 1, act: 0, hb: 1, ls: 0, x: 0,   y: 0};
    vecs[2] = '{n: 655, hs: 1, act: 0, hb: 1, ls: 0, x: 0,   y: 0};
    vecs[3] = '{n: 656, hs: 0, act: 0, hb: 1, ls: 0, x: 0,   y: 0};
    vecs[4] = '{n: 751, hs: 0, act: 0, hb: 1, ls: 0, x: 0,   y: 0};
    vecs[5] = '{n: 752, hs: 1, act: 0, hb: 1, ls: 0, x: 0,   y: 0};
    vecs[6] = '{n: 799, hs: 1, act: 0, hb: 1, ls: 0, x: 0,   y: 0};
    vecs[7] = '{n: 800, hs: 1, act: 1, hb: 0, ls: 1, x: 0,   y: 1};
    vecs[8] = '{n: 801, hs: 1, act: 1, hb: 0, ls: 0, x: 1,   y: 1};

    rst_a = 1'b1; rst_bc = 1'b1; en_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pix_stb", vif_a.o_pix_stb, 0);
    chk("rst_hsync", vif_a.o_hsync, 1);
    chk("rst_vsync", vif_a.o_vsync, 1);
    chk("rst_active", vif_a.o_active, 1);
    chk("rst_h_blank", vif_a.o_h_blank, 0);
    chk("rst_v_blank", vif_a.o_v_blank, 0);
    chk("rst_x", vif_a.o_x, 0);
    chk("rst_y", vif_a.o_y, 0);
    chk("rst_line_start", vif_a.o_line_start, 0);
    chk("rst_frame_start", vif_a.o_frame_start, 0);
    chk("rst_b_hsync", vif_b.o_hsync, 0);
    chk("rst_b_vsync", vif_b.o_vsync, 0);

    rst_a = 1'b0; rst_bc = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      chk($sformatf("stb_cadence_clk%0d", i), vif_a.o_pix_stb, (i == 5 || i == 9 || i == 13) ? 1 : 0);
      if (i == 4) chk("x_before_first_stb", vif_a.o_x, 0);
      if (i == 5) begin
        chk("first_stb_x", vif_a.o_x, 1);
        chk("first_stb_no_line_start", vif_a.o_line_start, 0);
        chk("first_stb_hsync", vif_a.o_hsync, 1);
        chk("first_stb_vsync", vif_a.o_vsync, 1);
      end
    end

    for (int i = 0; i < 9; i++) begin
      run_a_to(vecs[i].n);
      chk($sformatf("vec%0d_pix_stb", i), vif_a.o_pix_stb, 1);
      chk($sformatf("vec%0d_hsync", i), vif_a.o_hsync, vecs[i].hs);
      chk($sformatf("vec%0d_active", i), vif_a.o_active, vecs[i].act);
      chk($sformatf("vec%0d_h_blank", i), vif_a.o_h_blank, vecs[i].hb);
      chk($sformatf("vec%0d_x", i), vif_a.o_x, vecs[i].x);
      chk($sformatf("vec%0d_y", i), vif_a.o_y, vecs[i].y);
      chk($sformatf("vec%0d_line_start", i), vif_a.o_line_start, vecs[i].ls);
    end

    run_a_to(900);
    chk("gate_x_at_100", vif_a.o_x, 100);
    en_a = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      chk("gate_no_stb", vif_a.o_pix_stb, 0);
      chk("gate_x_hold", vif_a.o_x, 100);
    end
    en_a = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk); k++;
      seen = vif_a.o_pix_stb;
    end
    chk("gate_resume_stb", seen, 1);
    chk("gate_resume_x", vif_a.o_x, 101);

    run_a_to(1500);
    chk("pre_reset_hsync_h700", vif_a.o_hsync, 0);
    for (int g = 0; g < 8 && !sint_m[0]; g++) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_pix_stb", vif_a.o_pix_stb, 0);
    chk("midrst_hsync", vif_a.o_hsync, 1);
    chk("midrst_active", vif_a.o_active, 1);
    chk("midrst_h_blank", vif_a.o_h_blank, 0);
    chk("midrst_x", vif_a.o_x, 0);
    chk("midrst_y", vif_a.o_y, 0);
    chk("midrst_line_start", vif_a.o_line_start, 0);
    rst_a = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk); k++;
      seen = vif_a.o_pix_stb;
    end
    chk("midrst_first_stb_clk", k, 5);
    chk("midrst_resume_x", vif_a.o_x, 1);
    chk("midrst_resume_y", vif_a.o_y, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en_a  = ($urandom_range(0, 3) != 0);
      rst_a = ($urandom_range(0, 499) == 0);
    end
    rst_a = 1'b0; en_a = 1'b1;

    for (int g = 0; g < 20000 && !(done_b && done_c); g++) @(negedge clk);
    if (!(done_b && done_c)) begin
      checks++; errors++;
      $display("FAIL side_checks_timeout: got done_b=%0d done_c=%0d expected 1 1", done_b, done_c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // 800x600 positive-polarity line: length, hsync window and active span.
  initial begin
    int g, idx, hs_cnt, hs_first, act_cnt;
    @(negedge clk);
    while (rst_bc) @(negedge clk);
    g = 0;
    while (!vif_b.o_line_start && g < 5000) begin @(negedge clk); g++; end
    chk("b_line_start_seen", vif_b.o_line_start, 1);
    idx = 0; hs_cnt = 0; hs_first = -1; g = 0;
    act_cnt = vif_b.o_active ? 1 : 0;
    while (g < 5000) begin
      @(negedge clk); g++;
      if (vif_b.o_pix_stb) begin
        idx++;
        if (vif_b.o_line_start) break;
        if (vif_b.o_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = idx;
        end
        if (vif_b.o_active) act_cnt++;
      end
    end
    chk("b_line_strobes", idx, 1056);
    chk("b_hsync_first_h", hs_first, 840);
    chk("b_hsync_width", hs_cnt, 128);
    chk("b_active_pixels", act_cnt, 800);
    done_b = 1'b1;
  end

  // Tiny raster: first frame start after a full frame, then frame period and sync windows.
  initial begin
    int g, idx, hs_cnt, hs_first, vs_cnt, vs_first;
    @(negedge clk);
    while (rst_bc) @(negedge clk);
    idx = 0; g = 0;
    while (g < 3000) begin
      @(negedge clk); g++;
      if (vif_c.o_pix_stb) begin
        idx++;
        if (vif_c.o_frame_start) break;
      end
    end
    chk("c_first_frame_strobes", idx, 120);
    for (int f = 0; f < 2; f++) begin
      idx = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; g = 0;
      while (g < 3000) begin
        @(negedge clk); g++;
        if (vif_c.o_pix_stb) begin
          idx++;
          if (vif_c.o_frame_start) break;
          if (!vif_c.o_hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = idx;
          end
          if (!vif_c.o_vsync) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = idx;
          end
        end
      end
      chk($sformatf("c_frame%0d_strobes", f), idx, 120);
      chk($sformatf("c_frame%0d_hsync_count", f), hs_cnt, 24);
      chk($sformatf("c_frame%0d_hsync_first", f), hs_first, 10);
      chk($sformatf("c_frame%0d_vsync_count", f), vs_cnt, 30);
      chk($sformatf("c_frame%0d_vsync_first", f), vs_first, 75);
    end
    done_c = 1'b1;
  end

  // Random run enable for the tiny raster while its checks are in progress.
  initial begin
    @(negedge clk);
    while (!done_c) begin
      @(negedge clk);
      en_c = ($urandom_range(0, 3) != 0);
    end
    en_c = 1'b1;
  end

endmodule
